poly_voice_engine: RTL and testbench



---
 rtl/poly_voice_engine.sv | 200 ++++++++++++++++++++
 tb/tb_poly_voice_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic voice core: sawtooth phase + linear ADSR per voice, 3-stage mix pipeline.
// Optional feature macro POLY_VOICE_RETRIGGER_EN: a gate rise restarts phase and level from zero.
module poly_voice_engine #(
    parameter int VOICES     = 4,
    parameter int PHASE_BITS = 24,
    parameter int AMP_BITS   = 16,
    parameter int ENV_BITS   = 32,
    localparam int OUT_BITS  = AMP_BITS + $clog2(VOICES)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          sample_tick,
    input  logic [VOICES-1:0]             gate,
    input  logic [VOICES*PHASE_BITS-1:0]  freq_inc,
    input  logic [ENV_BITS-1:0]           attack_step,
    input  logic [ENV_BITS-1:0]           decay_step,
    input  logic [ENV_BITS-1:0]           sustain_level,
    input  logic [ENV_BITS-1:0]           release_step,
    output logic signed [OUT_BITS-1:0]    out_sample,
    output logic                          out_valid,
    output logic                          busy,
    output logic [VOICES-1:0]             active,
    output logic                          overrun
);

    localparam int CNT_BITS  = $clog2(VOICES + 3);
    localparam int VIDX_BITS = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT   = CNT_BITS'(VOICES + 2);
    localparam logic [CNT_BITS-1:0] VOICES_CNT = CNT_BITS'(VOICES);
    localparam logic [ENV_BITS:0]   ENV_MAX_X  = {1'b0, {ENV_BITS{1'b1}}};

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    env_state_t            env_state [VOICES];
    logic [ENV_BITS-1:0]   level     [VOICES];
    logic [PHASE_BITS-1:0] phase     [VOICES];
    logic [VOICES-1:0]     prev_gate;

    logic [CNT_BITS-1:0]   cnt;
    logic [VIDX_BITS-1:0]  vidx;
    logic                  s1_en;

    // S1 combinational results for the voice in its slot
    logic                  gate_now;
    logic                  rise;
    logic [PHASE_BITS-1:0] inc;
    logic [ENV_BITS-1:0]   base_level;
    logic [PHASE_BITS-1:0] base_phase;
    logic [ENV_BITS:0]     att_sum;
    env_state_t            eff_state;
    env_state_t            nxt_state;
    logic [ENV_BITS-1:0]   nxt_level;
    logic [PHASE_BITS-1:0] nxt_phase;

    // S2/S3 pipeline
    logic                       s2_valid, s2_last, s3_valid, s3_last;
    logic signed [AMP_BITS-1:0] s2_wave;
    logic signed [AMP_BITS:0]   s2_env;
    logic signed [2*AMP_BITS:0] prod;
    logic signed [AMP_BITS-1:0] s3_voice;
    logic signed [OUT_BITS-1:0] voice_ext;
    logic signed [OUT_BITS-1:0] acc;

    assign vidx  = cnt[VIDX_BITS-1:0];
    assign s1_en = busy && (cnt < VOICES_CNT);

    // NOTE: combinational blocks use blocking '=' and assign every output a default first so no latch is inferred.
    always_comb begin
        gate_now   = gate[vidx];
        rise       = gate_now && !prev_gate[vidx];
        inc        = freq_inc[vidx*PHASE_BITS +: PHASE_BITS];
        base_level = level[vidx];
        base_phase = phase[vidx];
`ifdef POLY_VOICE_RETRIGGER_EN
        if (rise) begin
            base_level = '0;
            base_phase = '0;
        end
`endif
        eff_state = env_state[vidx];
        if (rise)
            eff_state = ENV_ATTACK;
        else if (!gate_now && (eff_state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}))
            eff_state = ENV_RELEASE;

        att_sum   = {1'b0, base_level} + {1'b0, attack_step};
        nxt_state = eff_state;
        nxt_level = base_level;
        case (eff_state)
            ENV_ATTACK: begin
                if (att_sum >= ENV_MAX_X) begin
                    nxt_level = '1;
                    nxt_state = ENV_DECAY;
                end else begin
                    nxt_level = att_sum[ENV_BITS-1:0];
                end
            end
            ENV_DECAY: begin
                // Underflow counts as having passed the sustain level
                if (base_level <= decay_step || (base_level - decay_step) <= sustain_level) begin
                    nxt_level = sustain_level;
                    nxt_state = ENV_SUSTAIN;
                end else begin
                    nxt_level = base_level - decay_step;
                end
            end
            ENV_SUSTAIN: nxt_level = sustain_level;
            ENV_RELEASE: begin
                if (base_level <= release_step) begin
                    nxt_level = '0;
                    nxt_state = ENV_IDLE;
                end else begin
                    nxt_level = base_level - release_step;
                end
            end
            default: nxt_level = base_level;
        endcase
        nxt_phase = base_phase + inc;
    end

    assign prod      = (2*AMP_BITS+1)'(s2_wave) * (2*AMP_BITS+1)'(s2_env);
    assign voice_ext = OUT_BITS'(s3_voice);

    always_comb begin
        for (int v = 0; v < VOICES; v++)
            active[v] = (env_state[v] != ENV_IDLE);
    end

    // NOTE: the small per-voice state arrays are reset explicitly because reset must silence every voice.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            cnt        <= '0;
            overrun    <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            acc        <= '0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s3_valid   <= 1'b0;
            s3_last    <= 1'b0;
            prev_gate  <= '0;
            for (int v = 0; v < VOICES; v++) begin
                env_state[v] <= ENV_IDLE;
                level[v]     <= '0;
                phase[v]     <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            if (sample_tick && !busy) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                if (cnt == LAST_CNT)
                    busy <= 1'b0;
                else
                    cnt <= cnt + 1'b1;
            end
            if (sample_tick && busy)
                overrun <= 1'b1;

            if (s1_en) begin
                env_state[vidx] <= nxt_state;
                level[vidx]     <= nxt_level;
                phase[vidx]     <= nxt_phase;
                prev_gate[vidx] <= gate_now;
            end

            s2_valid <= s1_en;
            s2_last  <= (vidx == VIDX_BITS'(VOICES - 1));
            s3_valid <= s2_valid;
            s3_last  <= s2_last;

            if (s3_valid) begin
                if (s3_last) begin
                    out_sample <= acc + voice_ext;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc + voice_ext;
                end
            end
        end
    end

    // Datapath registers are qualified by the valid bits, so they carry no reset
    always_ff @(posedge clock) begin
        s2_wave  <= nxt_phase[PHASE_BITS-1 -: AMP_BITS];
        s2_env   <= {1'b0, nxt_level[ENV_BITS-1 -: AMP_BITS]};
        s3_voice <= prod[AMP_BITS +: AMP_BITS];
    end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Self-checking bench for poly_voice_engine: tick-level behavioural model, per-cycle compare, directed and random stimulus.
module tb_poly_voice_engine;

    localparam int VOICES     = 4;
    localparam int PHASE_BITS = 24;
    localparam int AMP_BITS   = 16;
    localparam int ENV_BITS   = 32;
    localparam int OUT_BITS   = AMP_BITS + $clog2(VOICES);
    localparam longint ENV_MAX    = (longint'(1) << ENV_BITS) - 1;
    localparam longint PHASE_MASK = (longint'(1) << PHASE_BITS) - 1;

    logic                         clock = 1'b0;
    logic                         reset_n;
    logic                         sample_tick;
    logic [VOICES-1:0]            gate;
    logic [VOICES*PHASE_BITS-1:0] freq_inc;
    logic [ENV_BITS-1:0]          attack_step, decay_step, sustain_level, release_step;
    logic signed [OUT_BITS-1:0]   out_sample;
    logic                         out_valid, busy, overrun;
    logic [VOICES-1:0]            active;

    poly_voice_engine #(
        .VOICES(VOICES), .PHASE_BITS(PHASE_BITS), .AMP_BITS(AMP_BITS), .ENV_BITS(ENV_BITS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .gate(gate),
        .freq_inc(freq_inc), .attack_step(attack_step), .decay_step(decay_step),
        .sustain_level(sustain_level), .release_step(release_step),
        .out_sample(out_sample), .out_valid(out_valid), .busy(busy),
        .active(active), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (one update per accepted tick) ----------------
    typedef enum int {M_IDLE, M_ATTACK, M_DECAY, M_SUSTAIN, M_RELEASE} m_stage_t;

    m_stage_t          m_stage [VOICES];
    longint            m_level [VOICES];
    longint            m_phase [VOICES];
    bit                m_prev  [VOICES];
    int                m_left, m_old_left;
    longint            m_out, m_pending;
    bit                m_ovr, m_valid;
    bit [VOICES-1:0]   m_act_old, m_act_new, exp_act;
    bit                chk_en = 1'b0;

    function automatic longint voice_value(longint ph, longint lv);
        longint w, e;
        w = ph >> (PHASE_BITS - AMP_BITS);
        if (w >= (longint'(1) << (AMP_BITS - 1))) w = w - (longint'(1) << AMP_BITS);
        e = lv >> (ENV_BITS - AMP_BITS);
        return (w * e) >>> AMP_BITS;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_stage[v] = M_IDLE;
            m_level[v] = 0;
            m_phase[v] = 0;
            m_prev[v]  = 1'b0;
        end
        m_left = 0; m_out = 0; m_pending = 0; m_ovr = 1'b0; m_valid = 1'b0;
        m_act_old = '0; m_act_new = '0;
    endfunction

    function automatic void model_accept();
        longint sum = 0;
        for (int v = 0; v < VOICES; v++) begin
            bit     g   = gate[v];
            bit     r   = g && !m_prev[v];
            longint inc = longint'(freq_inc[v*PHASE_BITS +: PHASE_BITS]);
            m_prev[v] = g;
`ifdef POLY_VOICE_RETRIGGER_EN
            if (r) begin
                m_level[v] = 0;
                m_phase[v] = 0;
            end
`endif
            if (r)
                m_stage[v] = M_ATTACK;
            else if (!g && (m_stage[v] == M_ATTACK || m_stage[v] == M_DECAY || m_stage[v] == M_SUSTAIN))
                m_stage[v] = M_RELEASE;
            case (m_stage[v])
                M_ATTACK: begin
                    m_level[v] = m_level[v] + longint'(attack_step);
                    if (m_level[v] >= ENV_MAX) begin m_level[v] = ENV_MAX; m_stage[v] = M_DECAY; end
                end
                M_DECAY: begin
                    m_level[v] = m_level[v] - longint'(decay_step);
                    if (m_level[v] <= longint'(sustain_level)) begin
                        m_level[v] = longint'(sustain_level);
                        m_stage[v] = M_SUSTAIN;
                    end
                end
                M_SUSTAIN: m_level[v] = longint'(sustain_level);
                M_RELEASE: begin
                    m_level[v] = m_level[v] - longint'(release_step);
                    if (m_level[v] <= 0) begin m_level[v] = 0; m_stage[v] = M_IDLE; end
                end
                default: ;
            endcase
            m_phase[v] = (m_phase[v] + inc) & PHASE_MASK;
            m_act_new[v] = (m_stage[v] != M_IDLE);
            sum = sum + voice_value(m_phase[v], m_level[v]);
        end
        m_pending = sum;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_old_left = m_left;
            m_valid = 1'b0;
            if (m_left > 0) m_left--;
            if (m_left == 1) begin
                m_valid = 1'b1;
                m_out   = m_pending;
            end
            if (sample_tick) begin
                if (m_old_left == 0) begin
                    m_act_old = m_act_new;
                    model_accept();
                    m_left = VOICES + 3;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            for (int v = 0; v < VOICES; v++)
                exp_act[v] = (m_left > 0 && m_left > VOICES + 2 - v) ? m_act_old[v] : m_act_new[v];
            check("busy", busy, m_left > 0);
            check("out_valid", out_valid, m_valid);
            check("out_sample", out_sample, m_out);
            check("overrun", overrun, m_ovr);
            check("active", active, exp_act);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_tick();
        @(posedge clock); #1 sample_tick = 1'b1;
        @(posedge clock); #1 sample_tick = 1'b0;
    endtask

    task automatic wait_sample(output longint s);
        s = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                s = out_sample;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL sample_timeout: got no out_valid expected one within 20 cycles at %0t", $time);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (busy === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy=1 expected 0 within 30 cycles at %0t", $time);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) n++;
        end
    endtask

    longint s;
    int     n;
    longint attack_exp [4] = '{longint'(1) << 30, longint'(1) << 31, longint'(3) << 30, ENV_MAX};

    initial begin
        reset_n = 1'b0; sample_tick = 1'b0; gate = '0; freq_inc = '0;
        attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clock);
        check("rst_out_sample", out_sample, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active, 0);
        check("rst_overrun", overrun, 0);

        // Attack ramp to full scale, then DECAY (decay_step 0 holds it)
        gate = 4'b0001;
        attack_step = 32'h4000_0000; decay_step = '0;
        sustain_level = 32'h8000_0000; release_step = 32'h4000_0000;
        for (int k = 0; k < 4; k++) begin
            pulse_tick();
            wait_sample(s);
            check("attack_level", m_level[0], attack_exp[k]);
        end
        check("attack_to_decay", m_stage[0], M_DECAY);
        check("attack_active", active, 4'b0001);

        // Sawtooth at half rate with voice 0 at full scale
        freq_inc[0 +: PHASE_BITS] = 24'h80_0000;
        pulse_tick(); wait_sample(s);
        check("saw_min", s, -32768);
        pulse_tick(); wait_sample(s);
        check("saw_zero", s, 0);

        // Decay into sustain, then release to idle
        decay_step = 32'h8000_0000;
        pulse_tick(); wait_sample(s);
        check("sustain_level", m_level[0], longint'(1) << 31);
        check("sustain_stage", m_stage[0], M_SUSTAIN);
        check("sustain_sample", s, -16384);
        gate = 4'b0000;
        pulse_tick(); wait_sample(s);
        check("release_level1", m_level[0], longint'(1) << 30);
        pulse_tick(); wait_sample(s);
        check("release_level2", m_level[0], 0);
        check("release_stage", m_stage[0], M_IDLE);
        @(negedge clock);
        check("release_active", active, 4'b0000);

        // Reset in the middle of a sequence
        wait_idle();
        gate = 4'b0011;
        freq_inc = {4{24'h12_3457}};
        pulse_tick();
        @(posedge clock); #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("midrst_out_sample", out_sample, 0);
        check("midrst_busy", busy, 0);
        check("midrst_active", active, 0);
        check("midrst_out_valid", out_valid, 0);
        count_valids(12, n);
        check("midrst_abandoned", n, 0);

        // Second tick two cycles after the first
        pulse_tick();
        @(posedge clock); #1 sample_tick = 1'b1;
        @(posedge clock); #1 sample_tick = 1'b0;
        count_valids(15, n);
        check("overlap_one_valid", n, 1);
        check("overlap_overrun", overrun, 1);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            wait_idle();
            @(posedge clock); #1;
            if ($urandom_range(0, 9) < 3) gate = VOICES'($urandom);
            for (int v = 0; v < VOICES; v++)
                freq_inc[v*PHASE_BITS +: PHASE_BITS] = PHASE_BITS'($urandom);
            attack_step   = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 6));
            decay_step    = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 6));
            sustain_level = $urandom;
            release_step  = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 6));
            sample_tick = 1'b1;
            @(posedge clock); #1 sample_tick = 1'b0;
            if (it % 50 == 49) begin
                @(posedge clock); #1 reset_n = 1'b0;
                repeat (2) @(posedge clock);
                #1 reset_n = 1'b1;
            end
            repeat ($urandom_range(0, 9)) begin
                @(posedge clock); #1;
                if ($urandom_range(0, 3) == 0) begin
                    sample_tick = 1'b1;
                    @(posedge clock); #1 sample_tick = 1'b0;
                end
            end
        end
        wait_idle();
        repeat (3) @(negedge clock);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
